kbd_spi_tx: RTL and testbench

Serial transmitter for the keyboard link between the PS/2 controller side and the main CPLD. It accepts a 40-key ZX matrix snapshot plus an 8-bit control-flag byte and shifts it out as one frame on the three-wire KBD_CS / KBD_CLK / KBD_DI interface. The receiving end samples KBD_DI on rising KBD_CLK while KBD_CS is low. The block runs in the controller domain and also serves as the stimulus master in the main-board keyboard benches.

---
 rtl/kbd_spi_pkg.sv | 44 ++++
 rtl/kbd_spi_tx_if.sv | 23 ++
 rtl/kbd_crc8.sv | 46 ++++
 rtl/kbd_spi_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_kbd_spi_tx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_spi_pkg.sv
// Shared definitions for the keyboard-link serial transmitter and its receiver:
// frame geometry, control-flag bit positions, CRC polynomial and FSM states.
// Optional feature macro: KBD_SPI_CRC_EN (appends a CRC-8 byte to every frame).
package kbd_spi_pkg;

  // Payload is {FLAGS, MATRIX}: 8 flag bits over 40 key bits.
  localparam int PAY_BITS = 48;

`ifdef KBD_SPI_CRC_EN
  localparam int FRAME_BITS = 56;
  localparam int BIT_W      = 7;
`else
  localparam int FRAME_BITS = 48;
  localparam int BIT_W      = 6;
`endif

  // Bit positions inside the FLAGS byte.
  localparam int FLAG_MAGIC = 7;
  localparam int FLAG_TURBO = 6;
  localparam int FLAG_PAUSE = 5;
  localparam int FLAG_RST   = 4;

  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } tx_state_e;

  // One serial CRC-8 step: MSB-first, non-reflected.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    if (fb) begin
      crc8_step = {crc[6:0], 1'b0} ^ CRC_POLY;
    end else begin
      crc8_step = {crc[6:0], 1'b0};
    end
  endfunction

endpackage

// File: rtl/kbd_spi_tx_if.sv
// Keyboard-link bundle: payload handshake towards the transmitter plus the
// three-wire serial lines it drives. The master modport is the transmitter;
// the slave modport is the requester/observer side.
interface kbd_spi_tx_if;
  logic [39:0] MATRIX;
  logic [7:0]  FLAGS;
  logic        TX_VALID;
  logic        TX_READY;
  logic        TX_DONE;
  logic        KBD_CS;
  logic        KBD_CLK;
  logic        KBD_DI;

  modport master (
    input  MATRIX, FLAGS, TX_VALID,
    output TX_READY, TX_DONE, KBD_CS, KBD_CLK, KBD_DI
  );

  modport slave (
    output MATRIX, FLAGS, TX_VALID,
    input  TX_READY, TX_DONE, KBD_CS, KBD_CLK, KBD_DI
  );
endinterface

// File: rtl/kbd_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00, MSB-first). clr restarts from zero and,
// when en is also high, folds din into the fresh remainder on the same edge.
// Shared between the keyboard-link transmitter and receiver.
module kbd_crc8
  import kbd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] base_s;

  // Pick the starting remainder, then fold in one data bit when enabled.
  always_comb begin
    base_s = crc_q;
    crc_d  = crc_q;
    if (clr) begin
      base_s = 8'h00;
    end else begin
      base_s = crc_q;
    end
    if (en) begin
      crc_d = crc8_step(base_s, din);
    end else begin
      crc_d = base_s;
    end
  end

  // Remainder register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/kbd_spi_tx.sv
// Keyboard-link serial transmitter. Latches {FLAGS, MATRIX} on accept and
// shifts it out MSB first on KBD_CS/KBD_CLK/KBD_DI; the receiver samples DI on
// rising KBD_CLK. Every serial output and handshake output is a flop.
// Optional feature macro: KBD_SPI_CRC_EN appends CRC-8 over the payload.
// When TX_VALID is still high on the last GAP cycle the next frame is accepted
// directly on that edge, so held requests see exactly GAP_CLKS of CS-high.
module kbd_spi_tx
  import kbd_spi_pkg::*;
#(
  parameter int CLK_DIV  = 7,
  parameter int GAP_CLKS = 14
) (
  input  logic        CLK_14MHZ,
  input  logic        RESET_n,
  kbd_spi_tx_if.master bus
);

  localparam int PH_W  = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(GAP_CLKS + 1);

  localparam logic [PH_W-1:0]  PH_ZERO  = PH_W'(0);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  last_q, last_d;
  logic [PAY_BITS-1:0]   shift_q, shift_d;
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic                  di_q, di_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic                  start_s;
  logic                  gap_entry_s;
  logic                  phase_end_s;
  logic                  gap_end_s;
  logic [PAY_BITS-1:0]   payload_s;

`ifdef KBD_SPI_CRC_EN
  localparam logic [BIT_W-1:0] BIT_PAY_LAST = BIT_W'(PAY_BITS - 1);
  logic                  crc_en_s;
  logic                  crc_bit_s;
  logic [7:0]            crc_s;

  kbd_crc8 u_crc (
    .clk   (CLK_14MHZ),
    .rst_n (RESET_n),
    .clr   (start_s),
    .en    (crc_en_s),
    .din   (crc_bit_s),
    .crc   (crc_s)
  );
`endif

  assign payload_s   = {bus.FLAGS, bus.MATRIX};
  assign phase_end_s = (phase_q == PH_LAST);
  assign gap_end_s   = (gap_q == GAP_LAST);

  // Frame sequencer: next state, counters, shift register and output flops.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    gap_d       = gap_q;
    bit_d       = bit_q;
    last_d      = last_q;
    shift_d     = shift_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    di_d        = di_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    start_s     = 1'b0;
    gap_entry_s = 1'b0;
`ifdef KBD_SPI_CRC_EN
    crc_en_s    = 1'b0;
    crc_bit_s   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.TX_VALID && ready_q) begin
          start_s = 1'b1;
        end else begin
          phase_d = PH_ZERO;
        end
      end

      SETUP: begin
        if (phase_end_s) begin
          state_d = HIGH;
          sck_d   = 1'b1;
          phase_d = PH_ZERO;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      HIGH: begin
        if (phase_end_s) begin
          state_d = LOW;
          sck_d   = 1'b0;
          phase_d = PH_ZERO;
          if (bit_q == BIT_LAST) begin
            // Final bit already clocked: hold DI for the trailing low phase.
            last_d = 1'b1;
          end else begin
            bit_d = bit_q + BIT_ONE;
`ifdef KBD_SPI_CRC_EN
            if (bit_q == BIT_PAY_LAST) begin
              // Payload exhausted: the finished CRC takes over the shifter.
              di_d    = crc_s[7];
              shift_d = {crc_s, 40'd0};
            end else begin
              di_d      = shift_q[PAY_BITS-2];
              shift_d   = {shift_q[PAY_BITS-2:0], 1'b0};
              crc_en_s  = (bit_q < BIT_PAY_LAST);
              crc_bit_s = shift_q[PAY_BITS-2];
            end
`else
            di_d    = shift_q[PAY_BITS-2];
            shift_d = {shift_q[PAY_BITS-2:0], 1'b0};
`endif
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      LOW: begin
        if (phase_end_s) begin
          phase_d = PH_ZERO;
          if (last_q) begin
            state_d     = GAP;
            cs_d        = 1'b1;
            di_d        = 1'b0;
            gap_d       = GAP_ZERO;
            gap_entry_s = 1'b1;
          end else begin
            state_d = HIGH;
            sck_d   = 1'b1;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end

      GAP: begin
        if (gap_end_s) begin
          if (bus.TX_VALID) begin
            start_s = 1'b1;
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = PH_ZERO;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        di_d    = 1'b0;
        ready_d = 1'b1;
      end
    endcase

    if (start_s) begin
      state_d = SETUP;
      phase_d = PH_ZERO;
      gap_d   = GAP_ZERO;
      bit_d   = BIT_ZERO;
      last_d  = 1'b0;
      shift_d = payload_s;
      cs_d    = 1'b0;
      sck_d   = 1'b0;
      di_d    = payload_s[PAY_BITS-1];
      ready_d = 1'b0;
      done_d  = 1'b0;
`ifdef KBD_SPI_CRC_EN
      crc_en_s  = 1'b1;
      crc_bit_s = payload_s[PAY_BITS-1];
`endif
    end else begin
      done_d = gap_entry_s;
    end
  end

  // State and output registers; reset drops the link idle immediately.
  always_ff @(posedge CLK_14MHZ or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      phase_q <= PH_ZERO;
      gap_q   <= GAP_ZERO;
      bit_q   <= BIT_ZERO;
      last_q  <= 1'b0;
      shift_q <= {PAY_BITS{1'b0}};
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      di_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      di_q    <= di_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.KBD_CS   = cs_q;
  assign bus.KBD_CLK  = sck_q;
  assign bus.KBD_DI   = di_q;
  assign bus.TX_READY = ready_q;
  assign bus.TX_DONE  = done_q;

endmodule

// File: tb/tb_kbd_spi_tx.sv
// Self-checking bench for kbd_spi_tx: directed sequence with random payloads,
// expected frames and edge times derived from the link's timing rules.
module tb_kbd_spi_tx;

  localparam int CLK_DIV  = 7;
  localparam int GAP_CLKS = 14;
`ifdef KBD_SPI_CRC_EN
  localparam int N = 56;
`else
  localparam int N = 48;
`endif
  localparam int CS_LOW  = CLK_DIV * (1 + 2 * N);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  kbd_spi_tx_if bus ();

  kbd_spi_tx #(.CLK_DIV(CLK_DIV), .GAP_CLKS(GAP_CLKS)) dut (
    .CLK_14MHZ (clk),
    .RESET_n   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed link activity, recorded on falling clock edges.
  logic [63:0] cur_bits = 64'd0;
  int          cur_n    = 0;
  logic [63:0] frm_q[$];
  int          len_q[$];
  int          cs_fall_q[$];
  int          cs_rise_q[$];
  int          rise_t[$];
  int          fall_t[$];
  int          done_cnt   = 0;
  int          rdy_rise_t = -1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic sck_p, cs_p, rdy_p;
    sck_p = 1'b0; cs_p = 1'b1; rdy_p = 1'b1;
    forever begin
      @(negedge clk);
      if (cs_p && !bus.KBD_CS) begin
        cur_bits = 64'd0; cur_n = 0; cs_fall_q.push_back(cyc);
      end
      if (!sck_p && bus.KBD_CLK) begin
        cur_bits = {cur_bits[62:0], bus.KBD_DI}; cur_n++; rise_t.push_back(cyc);
      end
      if (sck_p && !bus.KBD_CLK) fall_t.push_back(cyc);
      if (!cs_p && bus.KBD_CS) begin
        frm_q.push_back(cur_bits); len_q.push_back(cur_n); cs_rise_q.push_back(cyc);
      end
      if (!rdy_p && bus.TX_READY) rdy_rise_t = cyc;
      if (bus.TX_DONE === 1'b1) done_cnt++;
      sck_p = bus.KBD_CLK; cs_p = bus.KBD_CS; rdy_p = bus.TX_READY;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (checks %0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reference frame: payload MSB first, then (optionally) CRC-8 of the payload
  // obtained as the remainder of payload*x^8 divided by x^8+x^2+x+1.
  function automatic logic [63:0] exp_frame(input logic [47:0] p);
`ifdef KBD_SPI_CRC_EN
    logic [55:0] rem;
    rem = {p, 8'h00};
    for (int i = 55; i >= 8; i--) begin
      if (rem[i]) rem = rem ^ (56'h107 << (i - 8));
    end
    return {8'h00, p, rem[7:0]};
`else
    return {16'h0000, p};
`endif
  endfunction

  function automatic logic [47:0] rand_pay();
    logic [31:0] r1, r2;
    r1 = $urandom;
    r2 = $urandom;
    return {r2[31:28], 4'h0, r2[7:0], r1};
  endfunction

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (bus.TX_READY !== 1'b1 && t < 200) begin step(1); t++; end
    check(tag, bus.TX_READY, 1'b1);
  endtask

  task automatic start_frame(input logic [47:0] p, output int k);
    wait_ready("ready_before_start");
    bus.MATRIX = p[39:0];
    bus.FLAGS = p[47:40];
    bus.TX_VALID = 1'b1;
    k = cyc + 1;
    step(1);
    bus.TX_VALID = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int t;
    t = 0;
    while (frm_q.size() < n && t < 2000) begin step(1); t++; end
    check(tag, (frm_q.size() >= n), 1'b1);
  endtask

  task automatic frame_test(input logic [47:0] p, input string tag);
    int fi, d0, k;
    fi = frm_q.size();
    d0 = done_cnt;
    start_frame(p, k);
    wait_frames(fi + 1, {tag, "_end"});
    check({tag, "_bits"}, frm_q[fi], exp_frame(p));
    check({tag, "_len"}, len_q[fi], N);
    step(2);
    check({tag, "_done"}, done_cnt, d0 + 1);
  endtask

  initial begin
    logic [47:0] pa;
    int k, t, bad, fi, nf, d0;

    bus.MATRIX = 40'd0;
    bus.FLAGS = 8'd0;
    bus.TX_VALID = 1'b0;
    #1 rst_n = 1'b0;

    // Reset values.
    step(3);
    check("rst_cs", bus.KBD_CS, 1'b1);
    check("rst_clk", bus.KBD_CLK, 1'b0);
    check("rst_di", bus.KBD_DI, 1'b0);
    check("rst_ready", bus.TX_READY, 1'b1);
    check("rst_done", bus.TX_DONE, 1'b0);
    rst_n = 1'b1;
    step(20);
    check("idle_no_frame", cs_fall_q.size(), 0);
    check("idle_no_clk", rise_t.size(), 0);
    check("idle_ready", bus.TX_READY, 1'b1);

    // Single frame with exact edge timing.
    rise_t.delete();
    fall_t.delete();
    pa = 48'h80_0000000001;
    fi = frm_q.size();
    start_frame(pa, k);
    wait_frames(fi + 1, "single_end");
    check("single_done_at_cs_rise", bus.TX_DONE, 1'b1);
    check("single_gap_di", bus.KBD_DI, 1'b0);
    check("single_bits", frm_q[fi], exp_frame(pa));
    check("single_len", len_q[fi], N);
    check("single_cs_fall", cs_fall_q[fi], k);
    check("single_cs_rise", cs_rise_q[fi], k + CS_LOW);
    t = 0;
    while (bus.TX_READY !== 1'b1 && t < 100) begin step(1); t++; end
    check("single_ready_rise", rdy_rise_t, k + CS_LOW + GAP_CLKS);
    check("single_done_count", done_cnt, 1);
    bad = 0;
    if (rise_t.size() != N || fall_t.size() != N) bad++;
    for (int n = 0; n < N && n < rise_t.size() && n < fall_t.size(); n++) begin
      if (rise_t[n] != k + CLK_DIV + 2 * CLK_DIV * n) bad++;
      if (fall_t[n] != rise_t[n] + CLK_DIV) bad++;
    end
    check("sck_timing_errors", bad, 0);

    // Random payload frames.
    for (int i = 0; i < 4; i++) frame_test(rand_pay(), "rand");

    // Back-to-back with TX_VALID held and matrix changed mid-frame.
    wait_ready("b2b_ready");
    pa = rand_pay();
    fi = frm_q.size();
    nf = cs_fall_q.size();
    bus.MATRIX = pa[39:0];
    bus.FLAGS = pa[47:40];
    bus.TX_VALID = 1'b1;
    t = 0;
    while (cs_fall_q.size() <= nf && t < 50) begin step(1); t++; end
    check("b2b_first_accept", (cs_fall_q.size() > nf), 1'b1);
    step(100);
    bus.MATRIX = 40'hFF_FFFF_FFFF;
    t = 0;
    while (cs_fall_q.size() <= nf + 1 && t < 2000) begin step(1); t++; end
    check("b2b_second_accept", (cs_fall_q.size() > nf + 1), 1'b1);
    bus.TX_VALID = 1'b0;
    wait_frames(fi + 2, "b2b_end");
    check("b2b_frame1", frm_q[fi], exp_frame(pa));
    check("b2b_frame2", frm_q[fi + 1], exp_frame({pa[47:40], 40'hFF_FFFF_FFFF}));
    check("b2b_gap", cs_fall_q[nf + 1] - cs_rise_q[fi], GAP_CLKS);

    // Reset at the 20th KBD_CLK rise.
    pa = rand_pay();
    fi = frm_q.size();
    start_frame(pa, k);
    t = 0;
    while (cur_n < 20 && t < 1000) begin step(1); t++; end
    check("abort_reach_20", cur_n, 20);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("abort_cs_async", bus.KBD_CS, 1'b1);
    check("abort_clk", bus.KBD_CLK, 1'b0);
    check("abort_ready", bus.TX_READY, 1'b1);
    step(3);
    rst_n = 1'b1;
    step(2);
    check("abort_no_done", done_cnt, d0);
    check("abort_len", len_q[fi], 20);
    check("abort_bits", frm_q[fi], exp_frame(pa) >> (N - 20));
    frame_test(rand_pay(), "after_abort");

`ifdef KBD_SPI_CRC_EN
    frame_test(48'h0, "crc_zero");
    frame_test(48'h80_0000000001, "crc_pattern");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
